// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver: synchronise and filter both lines, decode 11-bit frames, queue results in a FWFT FIFO.
// Define PS2_RX_TIMEOUT_EN to add a watchdog that abandons stalled frames after TIMEOUT_CYCLES.

module ps2_rx_line_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic filt
);
  logic       sync_q1, sync_q2;
  logic [7:0] stable_cnt;

  // The filtered value only follows the synchroniser after FILTER_LEN consecutive differing samples
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q1    <= 1'b1;
      sync_q2    <= 1'b1;
      filt       <= 1'b1;
      stable_cnt <= '0;
    end else begin
      sync_q1 <= raw;
      sync_q2 <= sync_q1;
      if (sync_q2 == filt) begin
        stable_cnt <= '0;
      end else if (stable_cnt == 8'(FILTER_LEN - 1)) begin
        filt       <= sync_q2;
        stable_cnt <= '0;
      end else begin
        stable_cnt <= stable_cnt + 8'd1;
      end
    end
  end
endmodule

module ps2_rx_fifo #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                              CLK,
  input  logic                              RESET,
  input  logic                              CLK_MOUSE_IN,
  input  logic                              DATA_MOUSE_IN,
  input  logic                              READ_ENABLE,
  output logic [7:0]                        BYTE_READ,
  output logic [1:0]                        BYTE_ERROR_CODE,
  output logic                              BYTE_READY,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   FIFO_COUNT,
  output logic                              OVERFLOW
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = $clog2(FIFO_DEPTH);

  generate
    if (FILTER_LEN < 2 || FILTER_LEN > 255) begin : g_bad_filter
      $error("FILTER_LEN must be 2..255");
    end
    if (FIFO_DEPTH < 2 || FIFO_DEPTH > 64 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("FIFO_DEPTH must be a power of 2 in 2..64");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be positive");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic       clk_filt, data_filt, clk_prev, fall;
  state_t     state;
  logic [2:0] bit_cnt;
  logic [7:0] shift_reg;
  logic       parity_err;
  logic       wr_en;
  logic [9:0] wr_entry;

  ps2_rx_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
    .clk(CLK), .rst_n(RESET), .raw(CLK_MOUSE_IN), .filt(clk_filt)
  );

  ps2_rx_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filter (
    .clk(CLK), .rst_n(RESET), .raw(DATA_MOUSE_IN), .filt(data_filt)
  );

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) clk_prev <= 1'b1;
    else        clk_prev <= clk_filt;
  end

  assign fall = clk_prev & ~clk_filt;

`ifdef PS2_RX_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] wd_cnt;
`endif

  // Frame decoder; the data line is sampled only in fall-pulse cycles
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      shift_reg  <= '0;
      parity_err <= 1'b0;
`ifdef PS2_RX_TIMEOUT_EN
      wd_cnt     <= '0;
`endif
    end else if (fall) begin
`ifdef PS2_RX_TIMEOUT_EN
      wd_cnt <= '0;
`endif
      case (state)
        IDLE: begin
          if (!data_filt) begin
            state   <= DATA;
            bit_cnt <= '0;
          end
        end
        DATA: begin
          shift_reg <= {data_filt, shift_reg[7:1]};
          bit_cnt   <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state <= PARITY;
        end
        PARITY: begin
          parity_err <= ~(^shift_reg ^ data_filt);
          state      <= STOP;
        end
        STOP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
`ifdef PS2_RX_TIMEOUT_EN
    else if (state != IDLE) begin
      if (wd_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
        state  <= IDLE;
        wd_cnt <= '0;
      end else begin
        wd_cnt <= wd_cnt + 1'b1;
      end
    end else begin
      wd_cnt <= '0;
    end
`endif
  end

  assign wr_en    = fall && (state == STOP);
  assign wr_entry = {~data_filt, parity_err, shift_reg};

  logic [9:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  logic          full, empty, pop, push;

  assign full  = (count == CW'(FIFO_DEPTH));
  assign empty = (count == '0);
  assign pop   = READ_ENABLE & ~empty;
  // A full FIFO still accepts a frame when the head leaves in the same cycle
  assign push  = wr_en & (~full | pop);

  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= wr_entry;
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      OVERFLOW <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (wr_en && full && !pop) OVERFLOW <= 1'b1;
      else if (pop)              OVERFLOW <= 1'b0;
    end
  end

  assign BYTE_READY      = ~empty;
  assign FIFO_COUNT      = count;
  assign BYTE_READ       = empty ? 8'h00 : mem[rd_ptr][7:0];
  assign BYTE_ERROR_CODE = empty ? 2'b00 : mem[rd_ptr][9:8];
endmodule

// File: doc/ps2_rx_fifo.md
PS2_RX_FIFO -- requirements
Module: ps2_rx_fifo

Interface
REQ-001 SHALL have parameter FILTER_LEN, default 8: number of consecutive stable CLK-domain samples a PS/2 line needs before its filtered value changes (range 2-255).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 50000: the maximum number of idle CLK cycles allowed between filtered PS/2 clock falling edges inside a frame.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4: the number of received entries, a power of 2 in the range 2-64.
REQ-004 SHALL have port CLK  input  1  system clock; all logic runs on its rising edge.
REQ-005 SHALL have port RESET  input  1  asynchronous, active-low reset (0 = reset).
REQ-006 SHALL have port CLK_MOUSE_IN  input  1  raw PS/2 clock line, asynchronous to CLK.
REQ-007 SHALL have port DATA_MOUSE_IN  input  1  raw PS/2 data line, asynchronous to CLK.
REQ-008 SHALL have port READ_ENABLE  input  1  pops the FIFO head when BYTE_READY=1.
REQ-009 SHALL have port BYTE_READ  output  8  data byte of the FIFO head entry.
REQ-010 SHALL have port BYTE_ERROR_CODE  output  2  error code of the head entry: bit0 = parity error, bit1 = stop-bit error.
REQ-011 SHALL have port BYTE_READY  output  1  high while the FIFO is not empty.
REQ-012 SHALL have port FIFO_COUNT  output  clog2(FIFO_DEPTH+1)  number of stored entries.
REQ-013 SHALL have port OVERFLOW  output  1  sticky flag: a completed frame was dropped because the FIFO was full.

Function
REQ-014 SHALL pass both raw lines through a 2-flop synchroniser, then a stability filter: a filtered line changes only after FILTER_LEN consecutive identical synchronised samples.
REQ-015 SHALL generate a one-cycle fall pulse in the cycle after the filtered clock goes from 1 to 0, and SHALL sample the filtered data line in that cycle.
REQ-016 SHALL implement the frame FSM IDLE -> DATA -> PARITY -> STOP -> IDLE, advancing one state per fall pulse.
REQ-017 SHALL, in IDLE, enter DATA on a fall pulse only when sampled data=0; a sample of 1 SHALL be ignored and the FSM SHALL stay in IDLE.
REQ-018 SHALL, in DATA, shift in 8 bits LSB first using a 3-bit counter, moving to PARITY after the 8th bit.
REQ-019 SHALL set parity error when data byte XOR parity bit XOR 1 equals 1 (odd parity expected).
REQ-020 SHALL set stop error when the sampled stop bit is 0.
REQ-021 SHALL, on the STOP fall pulse, write {error code, byte} into the FIFO in that cycle; BYTE_READY SHALL rise in the next cycle. Frames with errors are stored, not discarded.
REQ-022 SHALL present the FIFO as first-word-fall-through: BYTE_READ and BYTE_ERROR_CODE always show the head entry, and are don't-care when empty.
REQ-023 SHALL make READ_ENABLE=1 with BYTE_READY=1 remove the head at the clock edge; READ_ENABLE while empty SHALL have no effect.
REQ-024 SHALL make a write while full, with no simultaneous pop, drop the new frame, set OVERFLOW, and leave contents and FIFO_COUNT unchanged.
REQ-025 SHALL make a simultaneous write and pop while full both take effect, leaving FIFO_COUNT unchanged and OVERFLOW unaffected.
REQ-026 SHALL clear OVERFLOW on the first successful pop after it was set, or on reset.
REQ-027 SHALL wrap read and write pointers modulo FIFO_DEPTH.

Reset
REQ-028 SHALL, while RESET=0, asynchronously force: FSM=IDLE, FIFO empty, FIFO_COUNT=0, BYTE_READY=0, BYTE_READ=0x00, BYTE_ERROR_CODE=00, OVERFLOW=0, synchronisers and filters=1, timeout counter=0.
REQ-029 SHALL discard a partially received frame when reset is asserted mid-frame; after release, reception SHALL restart from IDLE.

Configuration
REQ-030 SHALL, with PS2_RX_TIMEOUT_EN defined, use a watchdog counter that clears on every fall pulse and counts while FSM is not IDLE; on reaching TIMEOUT_CYCLES the FSM SHALL return to IDLE and the partial frame SHALL be discarded with no FIFO write.
REQ-031 SHALL, without PS2_RX_TIMEOUT_EN, contain no watchdog: the FSM holds mid-frame indefinitely until the frame completes or reset.

Verification
REQ-032 SHALL cover: frame 0xFA, parity 1, stop 1 -> one entry, BYTE_READ=0xFA, BYTE_ERROR_CODE=00, FIFO_COUNT=1.
REQ-033 SHALL cover: 0xF4 with parity 1 (incorrect) -> BYTE_ERROR_CODE=01; 0xF5 with parity 1 and stop 0 -> BYTE_ERROR_CODE=10.
REQ-034 SHALL cover: FIFO_DEPTH=4, 5 frames 0x01-0x05, no reads -> FIFO_COUNT=4, OVERFLOW=1, pops return 0x01-0x04, OVERFLOW=0 after the first pop.
REQ-035 SHALL cover: a 3-cycle low glitch on CLK_MOUSE_IN with FILTER_LEN=8 -> no fall pulse and FSM stays in IDLE.
REQ-036 SHALL cover, with PS2_RX_TIMEOUT_EN: start bit plus 3 data bits, then idle for more than TIMEOUT_CYCLES -> no entry; a following 0xF5 frame -> received with code 00.
REQ-037 SHALL cover: RESET=0 after the 5th data bit -> outputs take reset values; a following 0xFA frame -> received correctly.
